// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity-type encoding and
// small bit-level helper functions used by the receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Parity type encoding, common to transmitter and receiver
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Majority of three samples, used for noise-tolerant bit decisions
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage : uart_pkg

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and frame configuration in, parallel
// word plus status flags out.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    // Line side / consumer: drives the serial line and config, reads results
    modport master (
        output RX_IN, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err
    );

    // Receiver: reads the serial line and config, drives results
    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface : uart_rx_if

// File: rtl/uart_rx_sampler.sv
// Front end of the receiver: two-flop synchronizer, falling-edge detect and
// three-sample majority vote around the bit centre.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8,
    parameter int CW         = $clog2(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_in,
    input  logic [CW-1:0] edge_cnt,
    output logic          fall_edge,
    output logic          sampled_bit
);
    localparam logic [CW-1:0] SAMP0 = CW'(OVERSAMPLE/2 - 2);
    localparam logic [CW-1:0] SAMP1 = CW'(OVERSAMPLE/2 - 1);
    localparam logic [CW-1:0] SAMP2 = CW'(OVERSAMPLE/2);

    logic [1:0] sync_r;
    logic       rx_s;
    logic       rx_d_r;
    logic [2:0] samp_r;

    assign rx_s = sync_r[1];

    // Synchronize the asynchronous line and keep a delayed copy for edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= 2'b11;
            rx_d_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[0], rx_in};
            rx_d_r <= rx_s;
        end
    end

    // Capture the three centre samples of the current bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_r <= 3'b000;
        end else begin
            case (edge_cnt)
                SAMP0:   samp_r[0] <= rx_s;
                SAMP1:   samp_r[1] <= rx_s;
                SAMP2:   samp_r[2] <= rx_s;
                default: samp_r    <= samp_r;
            endcase
        end
    end

    assign fall_edge   = rx_d_r & ~rx_s;
    assign sampled_bit = majority3(samp_r[0], samp_r[1], samp_r[2]);

endmodule : uart_rx_sampler

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, bit/edge counters, deserializer and parity/stop
// checks. The bit value comes from the sampler's majority vote.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input logic      clk,
    input logic      rst,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] EDGE_DECIDE = CW'(OVERSAMPLE/2 + 1);
    localparam logic [CW-1:0] EDGE_LAST   = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_WIDTH - 1);

    rx_state_t             state_r;
    logic [CW-1:0]         edge_cnt_r;
    logic [BW-1:0]         bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  cfg_par_en_r;
    logic                  cfg_par_typ_r;
    logic [DATA_WIDTH-1:0] p_data_r;
    logic                  data_valid_r;
    logic                  par_err_r;
    logic                  stp_err_r;

    logic                  fall_edge_s;
    logic                  sampled_bit_s;
    logic                  decide_s;
    logic                  last_s;
    logic [CW-1:0]         edge_next_s;

    // Expected parity bit for a data word: even = XOR of bits, odd = inverted
    function automatic logic exp_parity(input logic [DATA_WIDTH-1:0] d, input logic typ);
        return (^d) ^ (typ == PAR_ODD);
    endfunction

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .CW         (CW)
    ) u_sampler (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (bus.RX_IN),
        .edge_cnt    (edge_cnt_r),
        .fall_edge   (fall_edge_s),
        .sampled_bit (sampled_bit_s)
    );

    // Bit-phase decode: decision point, end of bit and the wrapping edge count
    always_comb begin
        decide_s    = 1'b0;
        last_s      = 1'b0;
        edge_next_s = edge_cnt_r + CW'(1);
        if (edge_cnt_r == EDGE_DECIDE) begin
            decide_s = 1'b1;
        end else begin
            decide_s = 1'b0;
        end
        if (edge_cnt_r == EDGE_LAST) begin
            last_s      = 1'b1;
            edge_next_s = '0;
        end else begin
            last_s      = 1'b0;
        end
    end

    // Frame FSM with counters, deserializer and registered result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            edge_cnt_r    <= '0;
            bit_cnt_r     <= '0;
            shift_r       <= '0;
            cfg_par_en_r  <= 1'b0;
            cfg_par_typ_r <= PAR_EVEN;
            p_data_r      <= '0;
            data_valid_r  <= 1'b0;
            par_err_r     <= 1'b0;
            stp_err_r     <= 1'b0;
        end else begin
            data_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    edge_cnt_r <= '0;
                    bit_cnt_r  <= '0;
                    if (fall_edge_s) begin
                        // The detection cycle is edge 0 of the start bit
                        state_r       <= START;
                        edge_cnt_r    <= CW'(1);
                        cfg_par_en_r  <= bus.PAR_EN;
                        cfg_par_typ_r <= bus.PAR_TYP;
                        par_err_r     <= 1'b0;
                        stp_err_r     <= 1'b0;
                    end
                end
                START: begin
                    edge_cnt_r <= edge_next_s;
                    if (decide_s && sampled_bit_s) begin
                        // False start: line was only briefly low
                        state_r    <= IDLE;
                        edge_cnt_r <= '0;
                    end else if (last_s) begin
                        state_r <= DATA;
                    end
                end
                DATA: begin
                    edge_cnt_r <= edge_next_s;
                    if (decide_s) begin
                        shift_r[bit_cnt_r] <= sampled_bit_s;
                    end
                    if (last_s) begin
                        if (bit_cnt_r == BIT_LAST) begin
                            bit_cnt_r <= '0;
                            state_r   <= cfg_par_en_r ? PARITY : STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BW'(1);
                        end
                    end
                end
                PARITY: begin
                    edge_cnt_r <= edge_next_s;
                    if (decide_s) begin
                        par_err_r <= (sampled_bit_s != exp_parity(shift_r, cfg_par_typ_r));
                    end
                    if (last_s) begin
                        state_r <= STOP;
                    end
                end
                STOP: begin
                    edge_cnt_r <= edge_next_s;
                    if (decide_s) begin
                        // Leave early so a slightly fast transmitter is still caught
                        state_r    <= IDLE;
                        edge_cnt_r <= '0;
                        stp_err_r  <= ~sampled_bit_s;
                        if (sampled_bit_s && !par_err_r) begin
                            p_data_r     <= shift_r;
                            data_valid_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    edge_cnt_r <= '0;
                    bit_cnt_r  <= '0;
                end
            endcase
        end
    end

    assign bus.P_DATA     = p_data_r;
    assign bus.data_valid = data_valid_r;
    assign bus.par_err    = par_err_r;
    assign bus.stp_err    = stp_err_r;

endmodule : uart_rx

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the team's UART: the counterpart of the UART transmitter's output path. It recovers frames from the serial line: one start bit (0), DATA_WIDTH data bits LSB first, an optional even/odd parity bit, and one stop bit (1). It presents the byte in parallel with a single-cycle valid strobe and flags parity and stop errors. It runs on a clock at OVERSAMPLE × baud rate and uses 3-sample majority voting per bit.

## Interface
- DATA_WIDTH, 8, number of data bits per frame
- OVERSAMPLE, 8, clk cycles per bit; even, ≥ 6
- clk  input  1  receive clock, OVERSAMPLE × baud
- rst  input  1  asynchronous, active-low reset
- RX_IN  input  1  asynchronous serial line, idle high
- PAR_EN  input  1  1 = parity bit present in frame
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- P_DATA  output  DATA_WIDTH  last received data word
- data_valid  output  1  one-cycle strobe: P_DATA holds a clean frame
- par_err  output  1  parity mismatch on the last frame
- stp_err  output  1  stop bit sampled as 0 on the last frame

## Operation
- RX_IN passes through a 2-flop synchronizer (reset value 1), giving `rx_s`. A registered copy `rx_d` feeds edge detection.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - edge_cnt runs 0..OVERSAMPLE-1 within a bit.
  - bit_cnt runs 0..DATA_WIDTH-1 in DATA.
- Bit sampling: rx_s is captured at edge_cnt = OVERSAMPLE/2-2, OVERSAMPLE/2-1 and OVERSAMPLE/2. The bit value is the majority of the three and is decided at edge_cnt = OVERSAMPLE/2+1.
- IDLE:
  - A falling edge (rx_d=1, rx_s=0) is edge_cnt 0 of the start bit. Go to START.
  - Latch PAR_EN/PAR_TYP into frame config.
  - Clear par_err and stp_err.
- START: if the decided bit is 1 (false start), return to IDLE with no output change. Otherwise continue to DATA at the end of the bit (edge_cnt = OVERSAMPLE-1).
- DATA: each decided bit is shifted into bit position bit_cnt. After bit DATA_WIDTH-1, go to PARITY if the latched PAR_EN is 1, else to STOP.
- PARITY: par_err = decided bit ≠ expected parity.
  - Expected parity is the XOR of the data bits for even parity, or its inverse for odd parity.
  - par_err holds until the next start detection.
- STOP: at the decision point, go to IDLE immediately; the remainder of the stop bit is not waited out. Then:
  - stp_err = ~decided bit.
  - If both flags are clear: update P_DATA and pulse data_valid for one cycle.
  - If either flag is set: P_DATA keeps its old value and data_valid stays 0.
- Config changes mid-frame are ignored until the next start.
- A line held low after a stop error does not retrigger, because IDLE requires a falling edge.
- Reset (asserted at any time, including mid-frame): state IDLE, counters 0, P_DATA 0, data_valid 0, par_err 0, stp_err 0. The synchronizer flops reset to 1.

## Timing
- Cycle 0 is the cycle in which the falling edge is detected on rx_s; this is 2 clk after RX_IN falls.
- Stop decision at cycle N·OVERSAMPLE + OVERSAMPLE/2 + 1, where N = 1 + DATA_WIDTH + PAR_EN.
- data_valid, P_DATA and stp_err are registered one cycle after the stop decision.
  - Defaults with parity: cycle 86.
  - Defaults without parity: cycle 78.
- par_err is registered one cycle after the parity decision.
- Back-to-back frames: a start edge arriving anywhere after the stop decision is accepted. This tolerates a transmitter up to about 4% faster.
- No backpressure; the consumer must take P_DATA on data_valid. P_DATA is then stable until the next good frame.

## Structure
- Shared package uart_pkg:
  - FSM state enum (rx_state_t).
  - Parity-type constants PAR_EVEN=0 and PAR_ODD=1, shared with the transmitter's parity generator.
- Sub-module uart_rx_sampler: contains the synchronizer, edge detect and 3-sample majority vote. It is driven by edge_cnt and produces rx_s, fall_edge and sampled_bit.
- All other logic lives in uart_rx (FSM, counters, deserializer, parity/stop checks).

## Test plan
- 0xA5, PAR_EN=1, PAR_TYP=0, parity bit 0, stop 1 → data_valid pulse at cycle 86, P_DATA=0xA5, par_err=0, stp_err=0.
- 0xA5, PAR_EN=1, PAR_TYP=1, parity bit sent 0 → par_err=1, no data_valid, P_DATA unchanged.
- 0x3C, PAR_EN=0, stop bit driven 0 → stp_err=1, no data_valid. Line held low afterwards → no new frame until a high-then-low transition.
- 2-cycle low glitch on idle line → FSM returns to IDLE, no outputs change. A following valid 0x5A frame → P_DATA=0x5A.
- PAR_EN=0, frames 0x01, 0xFF, 0x80 back-to-back, each next start edge 4 cycles after the previous stop decision → three data_valid pulses with the correct words in order.
- Reset asserted during DATA of frame 0x77, released, then frame 0x12 sent → all outputs 0 during reset, no pulse for 0x77, then P_DATA=0x12.
